// File: rtl/tdc_stim_ctrl_pkg.sv
// Shared constants for the TDC stimulus/readout controller:
// default geometry, timing and FSM state encodings.
package tdc_stim_ctrl_pkg;

  localparam int NUM_STAGES  = 300;
  localparam int COARSE_W    = 8;
  localparam int TAP_W       = 9;
  localparam int PULSE_W     = 4;
  localparam int RECOVER_CYC = 8;

  localparam logic [2:0] TSC_IDLE    = 3'd0;
  localparam logic [2:0] TSC_ARM     = 3'd1;
  localparam logic [2:0] TSC_LAUNCH  = 3'd2;
  localparam logic [2:0] TSC_WAIT    = 3'd3;
  localparam logic [2:0] TSC_STOPHI  = 3'd4;
  localparam logic [2:0] TSC_RECOVER = 3'd5;

endpackage

// File: rtl/tdc_cycle_counter.sv
// Loadable down-counter with zero flag, shared by WAIT/STOPHI/RECOVER.
// Ports: clk, rst_n, load_i/val_i load, en_i decrement, cnt_o, zero_o.
module tdc_cycle_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tdc_stim_ctrl.sv
// TDC launch-side controller: START, delayed STOP, fine tap, code capture.
// Ports: req handshake + coarse/fine, abort, start/stop/fine_tap, result.
module tdc_stim_ctrl
  import tdc_stim_ctrl_pkg::*;
#(
  parameter int NS  = NUM_STAGES,
  parameter int CW  = COARSE_W,
  parameter int TW  = TAP_W,
  parameter int PW  = PULSE_W,
  parameter int RC  = RECOVER_CYC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [CW-1:0] coarse_dly,
  input  logic [TW-1:0] fine_sel,
  input  logic          abort,
  output logic          start,
  output logic          stop,
  output logic [TW-1:0] fine_tap,
  input  logic [NS-1:0] tdc_code,
  output logic          result_valid,
  output logic [NS-1:0] result_code,
  output logic          result_err
);

  logic [2:0]    state_q, state_d;
  logic          ready_q, ready_d;
  logic          start_q, start_d;
  logic          stop_q, stop_d;
  logic [TW-1:0] tap_q, tap_d;
  logic [TW-1:0] ftap_q, ftap_d;
  logic [CW-1:0] crs_q, crs_d;
  logic          clmp_q, clmp_d;
  logic          rv_q, rv_d;
  logic [NS-1:0] code_q, code_d;
  logic          rerr_q, rerr_d;

  logic          c_load, c_en, c_zero;
  logic [CW-1:0] c_val, c_cnt;
  logic          busy;

  tdc_cycle_counter #(.W(CW)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (c_load),
    .val_i  (c_val),
    .en_i   (c_en),
    .cnt_o  (c_cnt),
    .zero_o (c_zero)
  );

  assign busy = (state_q == TSC_ARM) || (state_q == TSC_LAUNCH) ||
                (state_q == TSC_WAIT) || (state_q == TSC_STOPHI);

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    stop_d  = stop_q;
    tap_d   = tap_q;
    ftap_d  = ftap_q;
    crs_d   = crs_q;
    clmp_d  = clmp_q;
    rv_d    = 1'b0;
    code_d  = code_q;
    rerr_d  = rerr_q;
    c_load  = 1'b0;
    c_val   = '0;
    c_en    = 1'b0;
    if (abort && busy) begin
      state_d = TSC_RECOVER;
      start_d = 1'b0;
      stop_d  = 1'b0;
      c_load  = 1'b1;
      c_val   = CW'(RC - 1);
    end else begin
      unique case (1'b1)
        (state_q == TSC_IDLE): begin
          if (req_valid && ready_q) begin
            crs_d = coarse_dly;
            if (fine_sel >= TW'(NS)) begin
              tap_d  = TW'(NS - 1);
              clmp_d = 1'b1;
            end else begin
              tap_d  = fine_sel;
              clmp_d = 1'b0;
            end
            state_d = TSC_ARM;
          end
        end
        (state_q == TSC_ARM): begin
          ftap_d  = tap_q;
          state_d = TSC_LAUNCH;
        end
        (state_q == TSC_LAUNCH): begin
          start_d = 1'b1;
          c_load  = 1'b1;
          c_val   = crs_q;
          state_d = TSC_WAIT;
        end
        (state_q == TSC_WAIT): begin
          if (c_zero) begin
            stop_d  = 1'b1;
            c_load  = 1'b1;
            c_val   = CW'(PW - 1);
            state_d = TSC_STOPHI;
          end else begin
            c_en = 1'b1;
          end
        end
        (state_q == TSC_STOPHI): begin
          // counter reads PW-2 on the second edge after stop rose
          if (c_cnt == CW'(PW - 2)) begin
            code_d = tdc_code;
            rerr_d = clmp_q;
            rv_d   = 1'b1;
          end
          if (c_zero) begin
            start_d = 1'b0;
            stop_d  = 1'b0;
            c_load  = 1'b1;
            c_val   = CW'(RC - 1);
            state_d = TSC_RECOVER;
          end else begin
            c_en = 1'b1;
          end
        end
        (state_q == TSC_RECOVER): begin
          if (c_zero) state_d = TSC_IDLE;
          else        c_en    = 1'b1;
        end
        default: state_d = TSC_IDLE;
      endcase
    end
    ready_d = (state_d == TSC_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TSC_IDLE;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      tap_q   <= '0;
      ftap_q  <= '0;
      crs_q   <= '0;
      clmp_q  <= 1'b0;
      rv_q    <= 1'b0;
      code_q  <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      tap_q   <= tap_d;
      ftap_q  <= ftap_d;
      crs_q   <= crs_d;
      clmp_q  <= clmp_d;
      rv_q    <= rv_d;
      code_q  <= code_d;
      rerr_q  <= rerr_d;
    end
  end

  assign req_ready    = ready_q;
  assign start        = start_q;
  assign stop         = stop_q;
  assign fine_tap     = ftap_q;
  assign result_valid = rv_q;
  assign result_code  = code_q;
  assign result_err   = rerr_q;

endmodule

// File: tb/tb_tdc_stim_ctrl.sv
// Self-checking bench for tdc_stim_ctrl: directed requests,
// scoreboard of expected results checked by a result monitor.
module tb_tdc_stim_ctrl;
  import tdc_stim_ctrl_pkg::*;

  localparam int NS = NUM_STAGES;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [7:0]    coarse_dly = '0;
  logic [8:0]    fine_sel = '0;
  logic          abort = 1'b0;
  logic          start, stop;
  logic [8:0]    fine_tap;
  logic [NS-1:0] tdc_code = '0;
  logic          result_valid;
  logic [NS-1:0] result_code;
  logic          result_err;

  typedef struct packed {
    logic [NS-1:0] code;
    logic          err;
  } res_t;

  res_t sb[$];
  int total = 0;
  int bad = 0;

  tdc_stim_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .coarse_dly   (coarse_dly),
    .fine_sel     (fine_sel),
    .abort        (abort),
    .start        (start),
    .stop         (stop),
    .fine_tap     (fine_tap),
    .tdc_code     (tdc_code),
    .result_valid (result_valid),
    .result_code  (result_code),
    .result_err   (result_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [NS-1:0] therm(input int k);
    logic [NS-1:0] ones;
    ones = '1;
    return ones >> (NS - k);
  endfunction

  // monitor: every strobe must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      res_t e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result: code=%h err=%0d", result_code,
                 result_err);
      end else begin
        e = sb.pop_front();
        if (result_code !== e.code || result_err !== e.err) begin
          bad++;
          $display("FAIL result: code=%h err=%0d expected code=%h err=%0d",
                   result_code, result_err, e.code, e.err);
        end
      end
    end
  end

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!req_ready && n < 400) begin
      tick();
      n++;
    end
    if (!req_ready) chk({nm, "_ready_timeout"}, 0, 1);
  endtask

  task automatic run_req(input logic [7:0] c, input logic [8:0] f,
                         input logic [NS-1:0] code,
                         input logic [8:0] etap, input logic eerr);
    int n;
    res_t r;
    wait_ready("req");
    tdc_code   = code;
    coarse_dly = c;
    fine_sel   = f;
    req_valid  = 1'b1;
    r.code = code;
    r.err  = eerr;
    sb.push_back(r);
    tick();
    req_valid = 1'b0;
    chk("ready_low_after_accept", req_ready, 0);
    tick();
    chk("fine_tap_at_A1", fine_tap, etap);
    chk("start_low_at_A1", start, 0);
    tick();
    chk("start_at_A2", start, 1);
    chk("stop_low_at_A2", stop, 0);
    n = 0;
    while (!stop && n < 300) begin
      tick();
      n++;
    end
    chk("start_to_stop", n, c + 1);
    tick();
    chk("no_strobe_S1", result_valid, 0);
    tick();
    chk("strobe_S2", result_valid, 1);
    tick();
    chk("strobe_end_S3", result_valid, 0);
    chk("stop_high_S3", stop, 1);
    tick();
    chk("start_fall_S4", start, 0);
    chk("stop_fall_S4", stop, 0);
  endtask

  initial begin
    int n;
    int cyc;
    logic prev_rdy, prev_stop;
    int acc[$];
    int fall[$];
    res_t r;

    #2;
    chk("rst_start", start, 0);
    chk("rst_stop", stop, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_tap", fine_tap, 0);
    #20 rst_n = 1'b1;
    tick();
    chk("ready_after_rst", req_ready, 1);

    // async reset in the middle of WAIT
    coarse_dly = 8'd50;
    fine_sel   = 9'd3;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    chk("midwait_start_high", start, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_start_low", start, 0);
    chk("async_stop_low", stop, 0);
    chk("async_rv_low", result_valid, 0);
    chk("async_ready_low", req_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("ready_after_rst2", req_ready, 1);
    chk("rv_after_rst2", result_valid, 0);
    chk("code_after_rst2", result_code == '0, 1);

    run_req(8'd5, 9'd17, therm(123), 9'd17, 1'b0);
    run_req(8'd0, 9'd0, therm(1), 9'd0, 1'b0);
    run_req(8'd255, 9'd299, therm(299), 9'd299, 1'b0);
    run_req(8'd3, 9'd400, therm(77), 9'd299, 1'b1);
    chk("err_flag_held", result_err, 1);

    // abort on capture edge: no strobe, prior code kept
    wait_ready("abort");
    tdc_code   = therm(200);
    coarse_dly = 8'd2;
    fine_sel   = 9'd9;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    n = 0;
    while (!stop && n < 50) begin
      tick();
      n++;
    end
    chk("abort_start_to_stop", n, 3);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_no_strobe", result_valid, 0);
    chk("abort_start_low", start, 0);
    chk("abort_stop_low", stop, 0);
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("abort_recover_cycles", n, RECOVER_CYC);
    chk("abort_code_kept", result_code == therm(77), 1);
    chk("abort_err_kept", result_err, 1);

    // back-to-back with req_valid held high
    tdc_code   = therm(42);
    coarse_dly = 8'd2;
    fine_sel   = 9'd5;
    r.code = therm(42);
    r.err  = 1'b0;
    sb.push_back(r);
    sb.push_back(r);
    req_valid = 1'b1;
    cyc = 0;
    prev_rdy  = req_ready;
    prev_stop = stop;
    while (acc.size() < 2 && cyc < 80) begin
      tick();
      cyc++;
      if (prev_rdy) acc.push_back(cyc);
      if (prev_stop && !stop) fall.push_back(cyc);
      prev_rdy  = req_ready;
      prev_stop = stop;
    end
    req_valid = 1'b0;
    if (acc.size() == 2 && fall.size() >= 1) begin
      chk("b2b_accept_after_fall", acc[1] - fall[0], RECOVER_CYC + 1);
      chk("b2b_accept_spacing", acc[1] - acc[0], 18);
    end else begin
      chk("b2b_two_accepts", acc.size(), 2);
    end
    wait_ready("b2b_end");
    repeat (3) tick();
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
